imm_alloc: RTL and testbench
============================

# imm_alloc

Allocator and write front-end for the 4-wide immediate storage. It tracks which 4-entry groups of the immediate table are in use and hands the lowest free group to each dispatch bundle. It returns the four entry tags to dispatch in the same cycle, and issues the registered group write (one-hot group select plus four data words) to the immediate storage one cycle later. Commit releases groups individually; a pipeline flush releases all of them.

## Interface
Parameters:
- SIZE, 32, total immediate entries; multiple of 4; G = SIZE/4 groups.
- WIDTH, 32, immediate data width.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  1  dispatch bundle wants a group this cycle.
- i_wdata0..i_wdata3  in  WIDTH each  immediates of the bundle's 4 slots.
- o_ready  out  1  at least one group free (combinational from state).
- o_tag0..o_tag3  out  $clog2(SIZE) each  entry index 4g+k of the selected group g (combinational).
- o_we  out  1  registered write strobe to immediate storage.
- o_waddr  out  G  registered one-hot group select; bit g = entries 4g..4g+3.
- o_wdata0..o_wdata3  out  WIDTH each  registered immediates, aligned with o_we.
- i_free  in  1  release one group (commit).
- i_free_grp  in  $clog2(G)  index of the group to release.
- i_flush  in  1  release all groups.
- o_count  out  $clog2(G)+1  number of free groups.

## Operation
- State: free bitmap fbm[G-1:0] (1 = free), count register, write output registers.
- Selection: g = lowest index with fbm[g]=1, from the registered bitmap only. o_tagk = 4g+k. When o_ready=0, all tags read 0.
- accept = i_req & o_ready & ~i_flush & ~i_rst. On accept, fbm[g] is cleared and the write is registered: o_we=1, o_waddr=1<<g, o_wdataK=i_wdataK.
- Without accept, o_we=0 next cycle. o_waddr and o_wdata hold their last values.
- Free: if fbm[i_free_grp]=0 (allocated), it is set next cycle. Freeing an already-free group is ignored and o_count is unchanged. An out-of-range index (≥G) is ignored.
- Same-cycle alloc and free:
  - Both take effect.
  - The freed group is not visible to selection until the next cycle.
  - A free naming the group being allocated in the same cycle is ignored, because that group was free beforehand.
- o_count next = o_count − accept + (valid free). This is consistent with popcount(fbm) at all times.
- Flush:
  - Next cycle, fbm is all ones and o_count=G.
  - A same-cycle request is not accepted.
  - A same-cycle free is absorbed.
  - An o_we already registered from an accept in the previous cycle still appears this cycle.
- Reset values: fbm all ones, o_count=G, o_we=0, o_waddr=0, o_wdata0..3=0.
  - o_ready=1 and o_tag0..3 = 0,1,2,3 from the first cycle after reset.
  - Requests during reset are dropped.

## Timing
- Tag latency: 0 cycles. Tags are valid in the request cycle when o_ready=1.
- Write latency: 1 cycle. An accept at edge N gives o_we/o_waddr/o_wdata valid between edges N and N+1, so the storage captures them at edge N+1.
- Free latency: 1 cycle. A group freed at edge N is selectable in the cycle after edge N.
- Full: when o_count=0, o_ready=0 and requests are dropped with no o_we. Dispatch must stall while o_ready=0.
- Throughput: one group per cycle, sustained while groups are free.
- Reset or flush mid-stream: takes effect at the next edge and overrides all same-cycle accepts and frees.

## Test plan
- Reset with SIZE=32:
  - After reset, o_count=8, o_ready=1, tags 0,1,2,3 and o_we=0.
  - Then one request with data A,B,C,D gives o_we=1, o_waddr=8'h01 and o_wdata=A,B,C,D on the next cycle.
- Fill: 8 back-to-back requests give tag bases 0,4,…,28 and o_waddr 01,02,…,80 on consecutive cycles. After that, o_ready=0 and o_count=0, and a 9th request produces no o_we.
- Free while full:
  - i_free with group 2 gives o_count=1 and o_ready=1 on the next cycle, with tags 8..11.
  - A request then gives o_waddr=8'h04.
- Simultaneous events:
  - State: groups 0–3 allocated.
  - Stimulus: a request and a free of group 1 in the same cycle.
  - Required: the request gets group 4 (not 1), o_count is unchanged, and group 1 is selected on the next request.
- Double free: free group 3 twice on consecutive cycles. o_count increments only once.
- Flush: with 5 groups allocated, assert i_flush together with i_req. No write follows, o_count=8 on the next cycle, and the next request gets tags 0..3.

Source files
------------

// File: rtl/imm_alloc.sv
// Group allocator and registered write front-end for the 4-wide immediate table.
// Hands out the lowest free 4-entry group per dispatch bundle; commit frees one group, flush frees all.
module imm_alloc #(
    parameter int SIZE  = 32,
    parameter int WIDTH = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_req,
    input  logic [WIDTH-1:0]            i_wdata0,
    input  logic [WIDTH-1:0]            i_wdata1,
    input  logic [WIDTH-1:0]            i_wdata2,
    input  logic [WIDTH-1:0]            i_wdata3,
    output logic                        o_ready,
    output logic [$clog2(SIZE)-1:0]     o_tag0,
    output logic [$clog2(SIZE)-1:0]     o_tag1,
    output logic [$clog2(SIZE)-1:0]     o_tag2,
    output logic [$clog2(SIZE)-1:0]     o_tag3,
    output logic                        o_we,
    output logic [SIZE/4-1:0]           o_waddr,
    output logic [WIDTH-1:0]            o_wdata0,
    output logic [WIDTH-1:0]            o_wdata1,
    output logic [WIDTH-1:0]            o_wdata2,
    output logic [WIDTH-1:0]            o_wdata3,
    input  logic                        i_free,
    input  logic [$clog2(SIZE/4)-1:0]   i_free_grp,
    input  logic                        i_flush,
    output logic [$clog2(SIZE/4):0]     o_count
);

    localparam int G  = SIZE / 4;
    localparam int GW = $clog2(G);
    localparam int TW = $clog2(SIZE);
    localparam int CW = GW + 1;
    localparam int PW = 2 ** GW;

    logic [G-1:0]  fbm;
    logic [G-1:0]  fbm_n;
    logic [G-1:0]  sel_oh;
    logic [PW-1:0] fbm_pad;
    logic [GW-1:0] sel;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          any_free;
    logic          accept;
    logic          free_ok;

    // Lowest set bit of the registered bitmap is the group handed out this cycle.
    assign sel_oh   = fbm & (~fbm + G'(1));
    assign any_free = |fbm;

    always_comb begin
        sel = '0;
        for (int g = G - 1; g >= 0; g--) begin
            if (fbm[g]) begin
                sel = GW'(g);
            end
        end
    end

    assign accept = i_req & any_free & ~i_flush & ~i_rst;

    // Out-of-range group indices read as already free, so their release is ignored.
    always_comb begin
        fbm_pad        = '1;
        fbm_pad[G-1:0] = fbm;
    end

    assign free_ok = i_free & ~fbm_pad[i_free_grp];

    always_comb begin
        fbm_n = fbm;
        for (int g = 0; g < G; g++) begin
            if (accept && sel_oh[g]) begin
                fbm_n[g] = 1'b0;
            end
            if (free_ok && (i_free_grp == GW'(g))) begin
                fbm_n[g] = 1'b1;
            end
        end
    end

    assign cnt_n = cnt + CW'(free_ok) - CW'(accept);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fbm      <= '1;
            cnt      <= CW'(G);
            o_we     <= 1'b0;
            o_waddr  <= '0;
            o_wdata0 <= '0;
            o_wdata1 <= '0;
            o_wdata2 <= '0;
            o_wdata3 <= '0;
        end else if (i_flush) begin
            fbm  <= '1;
            cnt  <= CW'(G);
            o_we <= 1'b0;
        end else begin
            fbm  <= fbm_n;
            cnt  <= cnt_n;
            o_we <= accept;
            if (accept) begin
                o_waddr  <= sel_oh;
                o_wdata0 <= i_wdata0;
                o_wdata1 <= i_wdata1;
                o_wdata2 <= i_wdata2;
                o_wdata3 <= i_wdata3;
            end
        end
    end

    assign o_ready = any_free;
    assign o_count = cnt;
    assign o_tag0  = any_free ? TW'({sel, 2'd0}) : '0;
    assign o_tag1  = any_free ? TW'({sel, 2'd1}) : '0;
    assign o_tag2  = any_free ? TW'({sel, 2'd2}) : '0;
    assign o_tag3  = any_free ? TW'({sel, 2'd3}) : '0;

endmodule

// File: tb/tb_imm_alloc.sv
// Bench for imm_alloc (SIZE=32): fixed vector table, hand-written corner sequences,
// then randomized traffic checked against a free-list model.
module tb_imm_alloc;
    localparam int SIZE  = 32;
    localparam int WIDTH = 32;
    localparam int G     = 8;

    logic        clk = 1'b0;
    logic        rst, req, free, flush;
    logic [2:0]  free_grp;
    logic [31:0] din0, din1, din2, din3;
    logic        ready, we;
    logic [4:0]  tag0, tag1, tag2, tag3;
    logic [7:0]  waddr;
    logic [31:0] dout0, dout1, dout2, dout3;
    logic [3:0]  count;

    always #5 clk = ~clk;

    imm_alloc #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .i_wdata0(din0), .i_wdata1(din1), .i_wdata2(din2), .i_wdata3(din3),
        .o_ready(ready), .o_tag0(tag0), .o_tag1(tag1), .o_tag2(tag2), .o_tag3(tag3),
        .o_we(we), .o_waddr(waddr),
        .o_wdata0(dout0), .o_wdata1(dout1), .o_wdata2(dout2), .o_wdata3(dout3),
        .i_free(free), .i_free_grp(free_grp), .i_flush(flush), .o_count(count)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic        pre_ready, pre_we;
    logic [4:0]  pre_tag [4];
    logic [3:0]  pre_count;
    logic        post_we;
    logic [7:0]  post_waddr;
    logic [31:0] post_wd [4];
    logic [31:0] last_din [4];

    typedef struct {
        logic       req;
        logic       fr;
        logic [2:0] fg;
        logic       ready;
        logic [4:0] tag0;
        logic [3:0] cnt;
        logic       we;
        logic [7:0] waddr;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(logic r, logic fr, logic [2:0] fg, logic rdy,
                                logic [4:0] t0, logic [3:0] c, logic w, logic [7:0] wa);
        vec_t v;
        v.req = r; v.fr = fr; v.fg = fg; v.ready = rdy;
        v.tag0 = t0; v.cnt = c; v.we = w; v.waddr = wa;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, sample combinational outputs before the edge, registered ones after it.
    task automatic step(input logic r, input logic fr, input logic [2:0] fg,
                        input logic fl, input logic rs);
        req = r; free = fr; free_grp = fg; flush = fl; rst = rs;
        din0 = $urandom; din1 = $urandom; din2 = $urandom; din3 = $urandom;
        last_din[0] = din0; last_din[1] = din1; last_din[2] = din2; last_din[3] = din3;
        #1;
        pre_ready = ready; pre_we = we; pre_count = count;
        pre_tag[0] = tag0; pre_tag[1] = tag1; pre_tag[2] = tag2; pre_tag[3] = tag3;
        @(posedge clk);
        #1;
        post_we = we; post_waddr = waddr;
        post_wd[0] = dout0; post_wd[1] = dout1; post_wd[2] = dout2; post_wd[3] = dout3;
        req = 1'b0; free = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    // Reference model: array of free flags plus the last write.
    bit          mfree [G];
    bit          mold  [G];
    logic        mwe;
    logic [7:0]  mwaddr;
    logic [31:0] mwd [4];

    initial begin
        rst = 1'b1; req = 1'b0; free = 1'b0; flush = 1'b0; free_grp = '0;
        din0 = '0; din1 = '0; din2 = '0; din3 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_count", count, 8);
        chk("rst_ready", ready, 1);
        chk("rst_tag0", tag0, 0);
        chk("rst_tag1", tag1, 1);
        chk("rst_tag2", tag2, 2);
        chk("rst_tag3", tag3, 3);
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata0", dout0, 0);

        // Fill, overflow request, free while full, re-allocate.
        tbl[0]  = mk(1, 0, 0, 1,  0, 8, 1, 8'h01);
        tbl[1]  = mk(1, 0, 0, 1,  4, 7, 1, 8'h02);
        tbl[2]  = mk(1, 0, 0, 1,  8, 6, 1, 8'h04);
        tbl[3]  = mk(1, 0, 0, 1, 12, 5, 1, 8'h08);
        tbl[4]  = mk(1, 0, 0, 1, 16, 4, 1, 8'h10);
        tbl[5]  = mk(1, 0, 0, 1, 20, 3, 1, 8'h20);
        tbl[6]  = mk(1, 0, 0, 1, 24, 2, 1, 8'h40);
        tbl[7]  = mk(1, 0, 0, 1, 28, 1, 1, 8'h80);
        tbl[8]  = mk(1, 0, 0, 0,  0, 0, 0, 8'h80);
        tbl[9]  = mk(0, 1, 2, 0,  0, 0, 0, 8'h80);
        tbl[10] = mk(0, 0, 0, 1,  8, 1, 0, 8'h80);
        tbl[11] = mk(1, 0, 0, 1,  8, 1, 1, 8'h04);
        tbl[12] = mk(0, 0, 0, 0,  0, 0, 0, 8'h04);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].req, tbl[i].fr, tbl[i].fg, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_ready", i), pre_ready, tbl[i].ready);
            chk($sformatf("tbl%0d_tag0", i), pre_tag[0], tbl[i].tag0);
            chk($sformatf("tbl%0d_tag3", i), pre_tag[3], tbl[i].ready ? tbl[i].tag0 + 5'd3 : 5'd0);
            chk($sformatf("tbl%0d_count", i), pre_count, tbl[i].cnt);
            chk($sformatf("tbl%0d_we", i), post_we, tbl[i].we);
            chk($sformatf("tbl%0d_waddr", i), post_waddr, tbl[i].waddr);
            if (tbl[i].we) begin
                for (int k = 0; k < 4; k++)
                    chk($sformatf("tbl%0d_wdata%0d", i, k), post_wd[k], last_din[k]);
            end
        end

        // Flush from full, then allocate groups 0..3.
        step(0, 0, 0, 1, 0);
        chk("flushfull_we", post_we, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0);
            chk($sformatf("refill%0d_count", i), pre_count, 8 - i);
            chk($sformatf("refill%0d_waddr", i), post_waddr, 8'h01 << i);
        end

        // Same-cycle request and free of group 1: request must get group 4.
        step(1, 1, 1, 0, 0);
        chk("simul_count_pre", pre_count, 4);
        chk("simul_tag0", pre_tag[0], 16);
        chk("simul_we", post_we, 1);
        chk("simul_waddr", post_waddr, 8'h10);
        step(1, 0, 0, 0, 0);
        chk("simul_count_after", pre_count, 4);
        chk("simul_next_tag0", pre_tag[0], 4);
        chk("simul_next_waddr", post_waddr, 8'h02);

        // Double free of group 3.
        step(0, 1, 3, 0, 0);
        chk("dfree_count0", pre_count, 3);
        step(0, 1, 3, 0, 0);
        chk("dfree_count1", pre_count, 4);
        step(0, 0, 0, 0, 0);
        chk("dfree_count2", pre_count, 4);
        step(1, 0, 0, 0, 0);
        chk("dfree_realloc_tag0", pre_tag[0], 12);
        chk("dfree_realloc_waddr", post_waddr, 8'h08);

        // Flush with 5 groups allocated and a same-cycle request.
        step(1, 0, 0, 1, 0);
        chk("flush_prev_we", pre_we, 1);
        chk("flush_count_pre", pre_count, 3);
        chk("flush_we", post_we, 0);
        step(1, 0, 0, 0, 0);
        chk("flush_count", pre_count, 8);
        chk("flush_tag0", pre_tag[0], 0);
        chk("flush_tag3", pre_tag[3], 3);
        chk("flush_next_we", post_we, 1);
        chk("flush_next_waddr", post_waddr, 8'h01);

        // Randomized traffic against the model.
        step(0, 0, 0, 0, 1);
        for (int g = 0; g < G; g++) mfree[g] = 1'b1;
        mwe = 1'b0; mwaddr = '0;
        for (int k = 0; k < 4; k++) mwd[k] = '0;

        for (int n = 0; n < 400; n++) begin
            logic       r, fr, fl, rs, e_ready, acc;
            logic [2:0] fg;
            int         e_sel, e_cnt;
            r  = ($urandom_range(0, 9) < 7);
            fr = ($urandom_range(0, 9) < 4);
            fg = 3'($urandom_range(0, 7));
            fl = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 49) == 0);
            e_ready = 1'b0; e_sel = 0; e_cnt = 0;
            for (int g = G - 1; g >= 0; g--) begin
                if (mfree[g]) begin
                    e_ready = 1'b1;
                    e_sel = g;
                    e_cnt++;
                end
            end
            step(r, fr, fg, fl, rs);
            chk("rnd_ready", pre_ready, e_ready);
            for (int k = 0; k < 4; k++)
                chk("rnd_tag", pre_tag[k], e_ready ? 4 * e_sel + k : 0);
            chk("rnd_count", pre_count, e_cnt);
            chk("rnd_we_pre", pre_we, mwe);

            acc = r && e_ready && !fl && !rs;
            if (rs) begin
                for (int g = 0; g < G; g++) mfree[g] = 1'b1;
                mwe = 1'b0; mwaddr = '0;
                for (int k = 0; k < 4; k++) mwd[k] = '0;
            end else if (fl) begin
                for (int g = 0; g < G; g++) mfree[g] = 1'b1;
                mwe = 1'b0;
            end else begin
                mold = mfree;
                if (acc) mfree[e_sel] = 1'b0;
                if (fr && !mold[fg]) mfree[fg] = 1'b1;
                mwe = acc;
                if (acc) begin
                    mwaddr = 8'h01 << e_sel;
                    for (int k = 0; k < 4; k++) mwd[k] = last_din[k];
                end
            end
            chk("rnd_we", post_we, mwe);
            chk("rnd_waddr", post_waddr, mwaddr);
            for (int k = 0; k < 4; k++)
                chk("rnd_wdata", post_wd[k], mwd[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
